ecall_ctrl: RTL and testbench

Pipeline-side initiator of the environment-call handshake with the register file. Detects an ECALL in execute, freezes the front of the pipeline, waits until older register writes have retired, then holds `ecall` until the register file returns `ecall_done`. On completion it redirects fetch to the instruction after the ECALL, because the call may have rewritten a0. It also counts completed calls and flags a handshake timeout.

---
 rtl/ecall_ctrl.sv | 115 +++++++++++
 tb/tb_ecall_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ecall_ctrl.sv
// Environment-call initiator: stalls the front end, waits for older register writes to retire,
// then holds the request until the register file completes it and redirects fetch past the ECALL.
module ecall_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ecall_valid,
  input  logic [63:0] ecall_pc,
  input  logic        inflight,
  output logic        ecall,
  input  logic        ecall_done,
  output logic        stall,
  output logic        flush,
  output logic [63:0] redirect_pc,
  output logic [31:0] ecall_count,
  output logic        error
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StDrain,
    StReq,
    StRelease,
    StError
  } state_e;

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [63:0]         pc_q, pc_d;
  logic [63:0]         redirect_pc_q, redirect_pc_d;
  logic [31:0]         count_q, count_d;
  logic                ecall_q, ecall_d;
  logic                flush_q, flush_d;
  logic                error_q, error_d;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    count_d       = count_q;
    unique case (state_q)
      StIdle: begin
        if (ecall_valid) begin
          pc_d    = ecall_pc;
          timer_d = '0;
          state_d = inflight ? StDrain : StReq;
        end
      end
      StDrain: begin
        if (!inflight) begin
          timer_d = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        // Completion wins over a timeout landing in the same cycle.
        if (ecall_done) begin
          redirect_pc_d = pc_q + 64'd4;
          state_d       = StRelease;
        end else if (timer_q == TimerMax) begin
          state_d = StError;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StRelease: begin
        count_d = count_q + 32'd1;
        state_d = StIdle;
      end
      StError: state_d = StError;
      default: state_d = StIdle;
    endcase
    // Outputs are registered from the next state so they line up with the state they describe.
    ecall_d = (state_d == StReq);
    flush_d = (state_d == StRelease);
    error_d = (state_d == StError);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      pc_q          <= '0;
      redirect_pc_q <= '0;
      count_q       <= '0;
      ecall_q       <= 1'b0;
      flush_q       <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
      count_q       <= count_d;
      ecall_q       <= ecall_d;
      flush_q       <= flush_d;
      error_q       <= error_d;
    end
  end

  assign stall = reset & (((state_q == StIdle) && ecall_valid) || (state_q == StDrain) ||
                          (state_q == StReq) || (state_q == StError));

  assign ecall       = ecall_q;
  assign flush       = flush_q;
  assign redirect_pc = redirect_pc_q;
  assign ecall_count = count_q;
  assign error       = error_q;

endmodule

// File: tb/tb_ecall_ctrl.sv
// Directed bench for ecall_ctrl: basic, drain, timeout, back-to-back, async reset and wrap cases.
module tb_ecall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ecall_valid;
  logic [63:0] ecall_pc;
  logic        inflight;
  logic        ecall;
  logic        ecall_done;
  logic        stall;
  logic        flush;
  logic [63:0] redirect_pc;
  logic [31:0] ecall_count;
  logic        error;

  int checks   = 0;
  int failures = 0;

  ecall_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .ecall_valid(ecall_valid),
    .ecall_pc   (ecall_pc),
    .inflight   (inflight),
    .ecall      (ecall),
    .ecall_done (ecall_done),
    .stall      (stall),
    .flush      (flush),
    .redirect_pc(redirect_pc),
    .ecall_count(ecall_count),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // A cycle starts 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    ecall_valid = 1'b0;
    ecall_pc    = '0;
    inflight    = 1'b0;
    ecall_done  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc();
  endtask

  int hi;

  initial begin
    // Reset state, including stall forced low even with a valid ECALL present.
    reset       = 1'b0;
    ecall_valid = 1'b1;
    ecall_pc    = 64'h1234;
    inflight    = 1'b0;
    ecall_done  = 1'b0;
    #3;
    check_eq("rst_stall", stall, 0);
    check_eq("rst_ecall", ecall, 0);
    check_eq("rst_flush", flush, 0);
    check_eq("rst_rpc", redirect_pc, 0);
    check_eq("rst_count", ecall_count, 0);
    check_eq("rst_error", error, 0);

    // Basic call.
    do_reset();
    ecall_valid = 1'b1; ecall_pc = 64'h1000;
    smp(); check_eq("b_c0_stall", stall, 1); check_eq("b_c0_ecall", ecall, 0);
    cyc(); ecall_valid = 1'b0;
    smp(); check_eq("b_c1_ecall", ecall, 1); check_eq("b_c1_stall", stall, 1);
    cyc(); ecall_done = 1'b1;
    smp(); check_eq("b_c2_ecall", ecall, 1); check_eq("b_c2_stall", stall, 1);
    cyc(); ecall_done = 1'b0;
    smp(); check_eq("b_c3_flush", flush, 1); check_eq("b_c3_rpc", redirect_pc, 64'h1004);
    check_eq("b_c3_stall", stall, 0); check_eq("b_c3_ecall", ecall, 0);
    check_eq("b_c3_count", ecall_count, 0);
    cyc();
    smp(); check_eq("b_c4_flush", flush, 0); check_eq("b_c4_count", ecall_count, 1);

    // Drain with inflight high for cycles 0-2 and a stray done in DRAIN.
    do_reset();
    ecall_valid = 1'b1; ecall_pc = 64'h2000; inflight = 1'b1;
    smp(); check_eq("d_c0_stall", stall, 1); check_eq("d_c0_ecall", ecall, 0);
    cyc(); ecall_valid = 1'b0; ecall_done = 1'b1;
    smp(); check_eq("d_c1_ecall", ecall, 0); check_eq("d_c1_stall", stall, 1);
    cyc(); ecall_done = 1'b0;
    smp(); check_eq("d_c2_ecall", ecall, 0);
    cyc(); inflight = 1'b0;
    smp(); check_eq("d_c3_ecall", ecall, 0); check_eq("d_c3_stall", stall, 1);
    cyc();
    smp(); check_eq("d_c4_ecall", ecall, 1);
    cyc(); ecall_done = 1'b1;
    smp(); check_eq("d_c5_flush", flush, 0);
    cyc(); ecall_done = 1'b0;
    smp(); check_eq("d_c6_flush", flush, 1); check_eq("d_c6_rpc", redirect_pc, 64'h2004);

    // Timeout with TIMEOUT_CYCLES = 8.
    do_reset();
    ecall_valid = 1'b1; ecall_pc = 64'h3000;
    smp();
    cyc(); ecall_valid = 1'b0;
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      smp();
      if (ecall === 1'b1) hi++;
      cyc();
    end
    check_eq("t_ecall_cycles", 64'(hi), 8);
    smp(); check_eq("t_error", error, 1); check_eq("t_stall", stall, 1);
    check_eq("t_ecall", ecall, 0);
    cyc(); ecall_done = 1'b1;
    cyc(); ecall_done = 1'b0;
    smp(); check_eq("t_late_error", error, 1); check_eq("t_late_ecall", ecall, 0);
    check_eq("t_late_flush", flush, 0); check_eq("t_late_stall", stall, 1);
    #1; reset = 1'b0; #1;
    check_eq("t_rst_error", error, 0); check_eq("t_rst_stall", stall, 0);

    // Back-to-back: valid held through RELEASE with a changing PC.
    do_reset();
    ecall_valid = 1'b1; ecall_pc = 64'h3000;
    smp();
    cyc();
    smp(); check_eq("bb_c1_ecall", ecall, 1);
    cyc(); ecall_done = 1'b1;
    smp();
    cyc(); ecall_done = 1'b0; ecall_pc = 64'h5000;
    smp(); check_eq("bb_c3_flush", flush, 1); check_eq("bb_c3_ecall", ecall, 0);
    check_eq("bb_c3_rpc", redirect_pc, 64'h3004); check_eq("bb_c3_stall", stall, 0);
    cyc(); ecall_pc = 64'h7000;
    smp(); check_eq("bb_c4_ecall", ecall, 0); check_eq("bb_c4_stall", stall, 1);
    check_eq("bb_c4_flush", flush, 0);
    cyc(); ecall_valid = 1'b0;
    smp(); check_eq("bb_c5_ecall", ecall, 1);
    cyc(); ecall_done = 1'b1;
    smp();
    cyc(); ecall_done = 1'b0;
    smp(); check_eq("bb_c7_flush", flush, 1); check_eq("bb_c7_rpc", redirect_pc, 64'h7004);
    check_eq("bb_c7_count", ecall_count, 1);
    cyc();
    smp(); check_eq("bb_c8_count", ecall_count, 2);

    // Asynchronous reset while in REQ.
    do_reset();
    ecall_valid = 1'b1; ecall_pc = 64'h4000;
    smp();
    cyc(); ecall_valid = 1'b0;
    smp(); check_eq("ar_req_ecall", ecall, 1);
    #2; reset = 1'b0; #1;
    check_eq("ar_ecall_async", ecall, 0); check_eq("ar_stall_async", stall, 0);
    @(posedge clk); #1;
    reset = 1'b1; ecall_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp(); check_eq("ar_no_flush", flush, 0); check_eq("ar_no_ecall", ecall, 0);
      cyc();
    end
    ecall_done = 1'b0;
    smp(); check_eq("ar_count", ecall_count, 0);
    cyc(); ecall_valid = 1'b1;
    smp(); check_eq("ar_idle_stall", stall, 1);
    cyc(); ecall_valid = 1'b0;
    smp(); check_eq("ar_idle_accept", ecall, 1);

    // Counter and PC wrap.
    do_reset();
    force dut.count_q = 32'hFFFF_FFFF;
    cyc();
    release dut.count_q;
    smp(); check_eq("w_preload", ecall_count, 32'hFFFF_FFFF);
    cyc(); ecall_valid = 1'b1; ecall_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    smp();
    cyc(); ecall_valid = 1'b0;
    smp();
    cyc(); ecall_done = 1'b1;
    smp();
    cyc(); ecall_done = 1'b0;
    smp(); check_eq("w_flush", flush, 1); check_eq("w_rpc", redirect_pc, 64'h0);
    cyc();
    smp(); check_eq("w_count", ecall_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
